mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRW, default 32, memory address width in bits.
REQ-002 Parameter DATAW, default 32, memory data width in bits.
REQ-003 Parameter MAX_WAIT, default 4, maximum consecutive conflict losses for instruction fetch before a forced IF grant; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  instruction-fetch read request.
REQ-007 if_addr  in  ADDRW  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch data valid.
REQ-010 if_rdata  out  DATAW  fetch data.
REQ-011 d_req  in  1  data-port request.
REQ-012 d_we  in  1  1 = write, 0 = read.
REQ-013 d_addr  in  ADDRW  data address.
REQ-014 d_wdata  in  DATAW  write data.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  data read data valid.
REQ-017 d_rdata  out  DATAW  data read data.
REQ-018 mem_en  out  1  single-port memory access strobe.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_addr  out  ADDRW  memory address.
REQ-021 mem_wdata  out  DATAW  memory write data.
REQ-022 mem_rdata  in  DATAW  memory read data, valid one cycle after a read strobe.

Function
REQ-023 The block SHALL share one single-port memory between the IF and data ports, issuing at most one access per cycle.
REQ-024 Grant logic SHALL be combinational: the winner's gnt, mem_en, mem_we, mem_addr and mem_wdata SHALL be driven in the same cycle as its req.
REQ-025 With one requester active, that requester SHALL be granted; with neither active, mem_en and both gnt outputs SHALL be 0.
REQ-026 On a conflict, the data port SHALL win unless the starvation guard forces an IF grant (REQ-036).
REQ-027 A read SHALL return data one cycle after its grant: the owner's rvalid = 1 and rdata = mem_rdata; the other port's rvalid = 0.
REQ-028 A registered response owner (NONE/IF/D) SHALL track the outstanding read, so back-to-back grants sustain one access per cycle.
REQ-029 Writes SHALL complete in the grant cycle and SHALL NOT raise d_rvalid.
REQ-030 rdata of a non-owner SHALL be 0.
REQ-031 A requester that is not granted SHALL hold req, address and write data stable until granted.

Reset
REQ-032 While rst = 1, all outputs SHALL be 0, the owner SHALL be NONE and the wait counter SHALL be 0.
REQ-033 Asserting rst with a read outstanding SHALL drop that read: no rvalid follows reset deassertion.
REQ-034 In the first cycle after reset deassertion, the block SHALL arbitrate normally.

Configuration
REQ-035 Macro ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-036 With ARB_STARVE_GUARD_EN defined:
- A 4-bit counter SHALL increment, saturating at MAX_WAIT, each cycle if_req = 1 and if_gnt = 0.
- When the counter equals MAX_WAIT, the next conflict SHALL grant IF.
- The counter SHALL clear on if_gnt.
REQ-037 Without ARB_STARVE_GUARD_EN, arbitration SHALL be fixed data priority and the counter SHALL NOT be built.

Structure
REQ-038 Shared package mem_arb_pkg SHALL hold the owner encoding (NONE = 2'd0, IF = 2'd1, D = 2'd2) and the default widths.
REQ-039 The starvation counter SHALL be a sub-module, arb_starve_ctr, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-040 IF-only read: if_req = 1, if_addr = 0x10, mem_rdata = 0x00000013 -> if_gnt same cycle; if_rvalid = 1 with if_rdata = 0x00000013 next cycle.
REQ-041 Conflict read: if_req = d_req = 1, d_we = 0, d_addr = 0x200 -> d_gnt = 1, if_gnt = 0, mem_addr = 0x200; d_rvalid next cycle.
REQ-042 Write: d_req = 1, d_we = 1, d_addr = 0x44, d_wdata = 0xDEADBEEF -> mem_we = 1 with that address and data; d_rvalid remains 0.
REQ-043 Guard on, MAX_WAIT = 4, both requests held for 6 cycles:
- d_gnt in cycles 1-4.
- if_gnt in cycle 5.
- d_gnt in cycle 6.
Guard off: d_gnt in all 6 cycles.
REQ-044 Back-to-back sequence D-read, IF-read, D-read -> 3 accesses in 3 cycles, each rvalid routed to the correct port.
REQ-045 Reset with a read outstanding -> no rvalid after release; owner = NONE; counter = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: response-owner encoding and default widths shared by mem_arbiter and its sub-blocks.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WAIT_W     = 4;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts consecutive fetch losses, saturating at MAX_WAIT, and raises force_if at the limit.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        force_if = cnt_q == WAIT_W'(MAX_WAIT);
        cnt_d    = if_gnt ? '0 : (if_req && !force_if) ? cnt_q + WAIT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch port and a data port, data port preferred.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after MAX_WAIT consecutive conflict losses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRW    = ADDR_W_DEF,
    parameter int DATAW    = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [ADDRW-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [DATAW-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [ADDRW-1:0] d_addr,
    input  logic [DATAW-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [DATAW-1:0] d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata
);
    logic [1:0] owner_q, owner_d;
    logic       force_if;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("mem_arbiter: MAX_WAIT must be in 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        if_gnt    = !rst && if_req && (!d_req || force_if);
        d_gnt     = !rst && d_req && !if_gnt;
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
        mem_wdata = mem_we ? d_wdata : '0;
        owner_d   = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
        if_rvalid = owner_q == OWN_IF;
        d_rvalid  = owner_q == OWN_D;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

    // Reset drops any outstanding read so no stale rvalid appears after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a cycle-level arbitration model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;
    int m_waits = 0;
    int m_pend  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDRW(AW), .DATAW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Winner this cycle: 0 = nobody, 1 = fetch, 2 = data.
    function automatic int m_winner();
        if (rst || !(if_req || d_req)) return 0;
        if (!d_req) return 1;
        if (!if_req) return 2;
        return (GUARD && m_waits >= MW) ? 1 : 2;
    endfunction

    task automatic tick();
        int w;
        w = m_winner();
        @(posedge clk);
        if (rst) begin
            m_pend  = 0;
            m_waits = 0;
        end else begin
            m_pend  = (w == 1) ? 1 : (w == 2 && !d_we) ? 2 : 0;
            m_waits = (w == 1) ? 0 : (if_req ? ((m_waits < MW) ? m_waits + 1 : MW) : m_waits);
        end
        #1;
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd; mem_rdata = rd;
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_pend = 0;
        m_waits = 0;
        drive(1, 'h10, 1, 1, 'h44, 'hDEADBEEF, 'h1234);
        tick();
        drive(1, 'h10, 1, 1, 'h44, 'hDEADBEEF, 'h5678);
        total++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        total++;
        if ({if_rdata, d_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_rdata: got %h %h want 0", if_rdata, d_rdata);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({if_gnt, d_gnt, mem_we} !== 3'b011) begin
            bad++;
            $display("FAIL reset_release_arb: got %b want 011", {if_gnt, d_gnt, mem_we});
        end
        tick();
    endtask

    task automatic test_if_read();
        drive(1, 'h10, 0, 0, '0, '0, $urandom);
        total++;
        if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 'h10) begin
            bad++;
            $display("FAIL if_read_grant: got gnt/en/we %b addr %h want 1010 addr 10",
                     {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
        end
        tick();
        drive(0, '0, 0, 0, '0, '0, 'h13);
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 'h13 || d_rdata !== '0) begin
            bad++;
            $display("FAIL if_read_data: got rv %b if_rdata %h d_rdata %h want 10 13 0",
                     {if_rvalid, d_rvalid}, if_rdata, d_rdata);
        end
        tick();
    endtask

    task automatic test_conflict();
        drive(1, 'h20, 1, 0, 'h200, '0, $urandom);
        total++;
        if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0110 || mem_addr !== 'h200) begin
            bad++;
            $display("FAIL conflict_grant: got %b addr %h want 0110 addr 200", {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
        end
        tick();
        drive(1, 'h20, 0, 0, '0, '0, 'hA5A5_0001);
        total++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b1001 || d_rdata !== 'hA5A5_0001 || mem_addr !== 'h20) begin
            bad++;
            $display("FAIL conflict_followup: got %b d_rdata %h addr %h want 1001 a5a50001 20",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid}, d_rdata, mem_addr);
        end
        tick();
        drive(0, '0, 0, 0, '0, '0, 'hA5A5_0002);
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 'hA5A5_0002) begin
            bad++;
            $display("FAIL conflict_if_data: got rv %b rdata %h want 10 a5a50002", {if_rvalid, d_rvalid}, if_rdata);
        end
        tick();
    endtask

    task automatic test_write();
        drive(0, '0, 1, 1, 'h44, 'hDEADBEEF, $urandom);
        total++;
        if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 'h44 || mem_wdata !== 'hDEADBEEF) begin
            bad++;
            $display("FAIL write_bus: got %b addr %h wdata %h want 111 44 deadbeef",
                     {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        drive(0, '0, 0, 0, '0, '0, $urandom);
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL write_no_rvalid: got %b want 00", {if_rvalid, d_rvalid});
        end
        tick();
    endtask

    task automatic test_reset_outstanding();
        for (int c = 0; c < 2; c++) begin
            drive(1, 'h60, 1, 0, 'h300 + 4 * c, '0, $urandom);
            tick();
        end
        rst = 1'b1;
        m_pend = 0;
        m_waits = 0;
        drive(0, '0, 0, 0, '0, '0, $urandom);
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL rst_drop_during: got %b want 00", {if_rvalid, d_rvalid});
        end
        tick();
        rst = 1'b0;
        drive(0, '0, 0, 0, '0, '0, $urandom);
        total++;
        if ({if_rvalid, d_rvalid, mem_en} !== 3'b000 || d_rdata !== '0) begin
            bad++;
            $display("FAIL rst_drop_after: got %b d_rdata %h want 000 0", {if_rvalid, d_rvalid, mem_en}, d_rdata);
        end
        tick();
    endtask

    task automatic test_starve();
        logic exp_if, prev_if, prev_d;
        logic [DW-1:0] rd;
        prev_if = 1'b0;
        prev_d  = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            rd = $urandom;
            drive(1, 'h80, 1, 0, 'h400 + 4 * c, '0, rd);
            exp_if = GUARD && c == 5;
            total++;
            if ({if_gnt, d_gnt} !== {exp_if, !exp_if} || mem_addr !== (exp_if ? 32'h80 : 32'h400 + 4 * c)) begin
                bad++;
                $display("FAIL starve_cycle%0d: got gnt %b addr %h want %b", c, {if_gnt, d_gnt}, mem_addr, {exp_if, !exp_if});
            end
            total++;
            if ({if_rvalid, d_rvalid} !== {prev_if, prev_d} || (prev_d && d_rdata !== rd) || (prev_if && if_rdata !== rd)) begin
                bad++;
                $display("FAIL starve_rvalid%0d: got %b want %b", c, {if_rvalid, d_rvalid}, {prev_if, prev_d});
            end
            prev_if = exp_if;
            prev_d  = !exp_if;
            tick();
        end
        drive(0, '0, 0, 0, '0, '0, $urandom);
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b01) begin
            bad++;
            $display("FAIL starve_tail: got %b want 01", {if_rvalid, d_rvalid});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] eg [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
        logic [1:0] er [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
        logic [DW-1:0] rd;
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            rd = $urandom;
            drive(k == 1, 'h50, k == 0 || k == 2, 0, 'h500 + 2 * k, '0, rd);
            n += int'(mem_en);
            total++;
            if ({if_gnt, d_gnt} !== eg[k] || {if_rvalid, d_rvalid} !== er[k]) begin
                bad++;
                $display("FAIL b2b_step%0d: got gnt %b rv %b want %b %b", k, {if_gnt, d_gnt}, {if_rvalid, d_rvalid}, eg[k], er[k]);
            end
            total++;
            if ((er[k][1] ? if_rdata : d_rdata) !== (er[k] == 2'b00 ? '0 : rd)) begin
                bad++;
                $display("FAIL b2b_rdata%0d: got %h %h want %h", k, if_rdata, d_rdata, rd);
            end
            tick();
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL b2b_access_count: got %0d want 3", n);
        end
    endtask

    task automatic test_random();
        logic ir, dr, dw, hold_if, hold_d;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] wd, rd;
        int w;
        hold_if = 1'b0;
        hold_d  = 1'b0;
        ir = 0; dr = 0; dw = 0; ia = '0; da = '0; wd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold_if) begin
                ir = $urandom_range(0, 9) < 6;
                ia = $urandom;
            end
            if (!hold_d) begin
                dr = $urandom_range(0, 9) < 6;
                dw = $urandom_range(0, 1) == 1;
                da = $urandom;
                wd = $urandom;
            end
            rd = $urandom;
            drive(ir, ia, dr, dw, da, wd, rd);
            w = m_winner();
            total++;
            if ({if_gnt, d_gnt, mem_en, mem_we} !== {w == 1, w == 2, w != 0, w == 2 && dw}) begin
                bad++;
                $display("FAIL rand_grant c%0d: got %b want %b waits %0d", c, {if_gnt, d_gnt, mem_en, mem_we},
                         {w == 1, w == 2, w != 0, w == 2 && dw}, m_waits);
            end
            if (w != 0) begin
                total++;
                if (mem_addr !== (w == 1 ? ia : da) || (w == 2 && dw && mem_wdata !== wd)) begin
                    bad++;
                    $display("FAIL rand_bus c%0d: got addr %h wdata %h want %h %h", c, mem_addr, mem_wdata, w == 1 ? ia : da, wd);
                end
            end
            total++;
            if ({if_rvalid, d_rvalid} !== {m_pend == 1, m_pend == 2} ||
                if_rdata !== (m_pend == 1 ? rd : '0) || d_rdata !== (m_pend == 2 ? rd : '0)) begin
                bad++;
                $display("FAIL rand_resp c%0d: got rv %b %h %h want owner %0d data %h", c, {if_rvalid, d_rvalid},
                         if_rdata, d_rdata, m_pend, rd);
            end
            hold_if = ir && w != 1;
            hold_d  = dr && w != 2;
            tick();
        end
        drive(0, '0, 0, 0, '0, '0, '0);
        tick();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_conflict();
        test_write();
        test_reset_outstanding();
        test_starve();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
